// File: rtl/bus_parser_pkg.sv
// ---------------------------------------------------------------------------
// bus_parser_pkg
// Shared definitions for the ASCII bus request parser and the BRAM core it
// feeds: ASCII protocol characters, parser state encoding, nibble counts for
// each message type and the bus field widths.
// No ports (package).
// ---------------------------------------------------------------------------
package bus_parser_pkg;

    // Bus field widths, shared with the downstream BRAM core
    localparam int ADDR_W = 16;
    localparam int DATA_W = 16;

    // Hex nibbles carried by each message type (address, or address + data)
    localparam int NIB_READ  = 4;
    localparam int NIB_WRITE = 8;

    // Nibble shift buffer is sized for the longest message
    localparam int BUF_W     = NIB_WRITE * 4;
    localparam int NIB_CNT_W = $clog2(NIB_WRITE + 1);

    // ASCII characters that steer the grammar
    localparam logic [7:0] CHAR_R  = 8'h52;
    localparam logic [7:0] CHAR_W  = 8'h57;
    localparam logic [7:0] CHAR_CR = 8'h0D;
    localparam logic [7:0] CHAR_LF = 8'h0A;

    typedef enum logic {
        IDLE    = 1'b0,
        ACQUIRE = 1'b1
    } parser_state_t;

    // Either line ending closes a message
    function automatic logic is_terminator(input logic [7:0] b);
        return (b == CHAR_CR) || (b == CHAR_LF);
    endfunction

    // 'R' or 'W' opens a message (and resynchronises a broken one)
    function automatic logic is_start(input logic [7:0] b);
        return (b == CHAR_R) || (b == CHAR_W);
    endfunction

endpackage

// File: rtl/bus_request_parser_hex_decoder.sv
// ---------------------------------------------------------------------------
// hex_ascii_decoder
// Purely combinational ASCII to hex-nibble conversion.
// Ports:
//   data    in  8  ASCII byte
//   is_hex  out 1  byte is a legal hex digit
//   nibble  out 4  value of the digit (0 when is_hex is 0)
// Parameter ACCEPT_LOWERCASE: when 1, 'a'-'f' are legal digits too.
// ---------------------------------------------------------------------------
module hex_ascii_decoder #(
    parameter bit ACCEPT_LOWERCASE = 1'b1
) (
    input  logic [7:0] data,
    output logic       is_hex,
    output logic [3:0] nibble
);

    // Classify the byte into one of the three digit ranges. For both letter
    // ranges the low nibble of 'A'/'a' is 1, so adding 9 yields 10..15.
    always_comb begin
        is_hex = 1'b0;
        nibble = 4'h0;
        if (data >= 8'h30 && data <= 8'h39) begin
            is_hex = 1'b1;
            nibble = data[3:0];
        end else if (data >= 8'h41 && data <= 8'h46) begin
            is_hex = 1'b1;
            nibble = data[3:0] + 4'd9;
        end else if (ACCEPT_LOWERCASE && data >= 8'h61 && data <= 8'h66) begin
            is_hex = 1'b1;
            nibble = data[3:0] + 4'd9;
        end
    end

endmodule

// File: rtl/bus_request_parser.sv
// ---------------------------------------------------------------------------
// bus_request_parser
// Turns the UART receive byte stream into single-cycle bus requests.
//   Read : 'R' + 4 hex digits + CR/LF
//   Write: 'W' + 4 hex addr + 4 hex data + CR/LF
// Ports:
//   clk      in  1   system clock, rising edge
//   rst_n    in  1   asynchronous active-low reset
//   data_i   in  8   received byte
//   valid_i  in  1   data_i valid this cycle
//   addr_o   out 16  request address (held until next request)
//   wdata_o  out 16  write data, 0 for reads (held until next request)
//   rdata_o  out 16  always 0, filled in by downstream cores
//   rw_o     out 1   1 = write, 0 = read (held until next request)
//   valid_o  out 1   one-cycle request strobe
//   err_o    out 1   one-cycle pulse when a message is discarded
// Parameter ACCEPT_LOWERCASE: accept 'a'-'f' as hex digits.
// ---------------------------------------------------------------------------
module bus_request_parser
    import bus_parser_pkg::*;
#(
    parameter bit ACCEPT_LOWERCASE = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data_i,
    input  logic              valid_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] wdata_o,
    output logic [DATA_W-1:0] rdata_o,
    output logic              rw_o,
    output logic              valid_o,
    output logic              err_o
);

    parser_state_t          state;
    logic [BUF_W-1:0]       nib_buf;
    logic [NIB_CNT_W-1:0]   nib_cnt;
    logic                   is_write;

    logic                   byte_is_hex;
    logic [3:0]             byte_nibble;
    logic [NIB_CNT_W-1:0]   need;

    hex_ascii_decoder #(
        .ACCEPT_LOWERCASE(ACCEPT_LOWERCASE)
    ) u_hex_decoder (
        .data   (data_i),
        .is_hex (byte_is_hex),
        .nibble (byte_nibble)
    );

    // The read data slot of the bus is owned by the cores further down.
    assign rdata_o = '0;

    // Number of digits the message in flight must carry before its terminator.
    always_comb begin
        need = is_write ? NIB_CNT_W'(NIB_WRITE) : NIB_CNT_W'(NIB_READ);
    end

    // Parser FSM. Strobes default low every cycle so valid_o/err_o are single
    // cycle pulses; the request fields only move when a request is issued.
    // A start character inside a message is treated as the beginning of a new
    // message so a lost terminator costs only one message. Both letter-range
    // checks come after the hex test, which is safe because 'R'/'W' are never
    // hex digits. A terminator seen in IDLE is dropped silently so CR+LF line
    // endings produce a single request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            nib_buf  <= '0;
            nib_cnt  <= '0;
            is_write <= 1'b0;
            addr_o   <= '0;
            wdata_o  <= '0;
            rw_o     <= 1'b0;
            valid_o  <= 1'b0;
            err_o    <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            err_o   <= 1'b0;
            if (valid_i) begin
                case (state)
                    IDLE: begin
                        if (is_start(data_i)) begin
                            state    <= ACQUIRE;
                            is_write <= (data_i == CHAR_W);
                            nib_cnt  <= '0;
                            nib_buf  <= '0;
                        end
                    end
                    ACQUIRE: begin
                        if (byte_is_hex) begin
                            if (nib_cnt < need) begin
                                nib_buf <= {nib_buf[BUF_W-5:0], byte_nibble};
                                nib_cnt <= nib_cnt + 1'b1;
                            end else begin
                                err_o <= 1'b1;
                                state <= IDLE;
                            end
                        end else if (is_terminator(data_i)) begin
                            state <= IDLE;
                            if (nib_cnt == need) begin
                                valid_o <= 1'b1;
                                rw_o    <= is_write;
                                if (is_write) begin
                                    addr_o  <= nib_buf[BUF_W-1:BUF_W-ADDR_W];
                                    wdata_o <= nib_buf[DATA_W-1:0];
                                end else begin
                                    addr_o  <= nib_buf[ADDR_W-1:0];
                                    wdata_o <= '0;
                                end
                            end else begin
                                err_o <= 1'b1;
                            end
                        end else if (is_start(data_i)) begin
                            err_o    <= 1'b1;
                            state    <= ACQUIRE;
                            is_write <= (data_i == CHAR_W);
                            nib_cnt  <= '0;
                            nib_buf  <= '0;
                        end else begin
                            err_o <= 1'b1;
                            state <= IDLE;
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bus_request_parser.sv
// ---------------------------------------------------------------------------
// tb_bus_request_parser
// Drives the same byte stream into two parser instances, one accepting
// lowercase hex and one not, and compares every output of both instances
// each cycle against a message-level reference model.
// ---------------------------------------------------------------------------
module tb_bus_request_parser;

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_i;
    logic        valid_i;

    logic [15:0] lc_addr, lc_wdata, lc_rdata;
    logic        lc_rw, lc_valid, lc_err;
    logic [15:0] uc_addr, uc_wdata, uc_rdata;
    logic        uc_rw, uc_valid, uc_err;

    int check_count;
    int pass_count;

    // Reference model: a message is a type letter plus a digit count and the
    // numeric value accumulated from the digits seen so far.
    typedef struct {
        bit          in_msg;
        bit          is_wr;
        int          ndig;
        int unsigned value;
        bit          exp_valid;
        bit          exp_err;
        logic [15:0] addr;
        logic [15:0] wdata;
        bit          rw;
    } model_t;

    model_t m_lc;
    model_t m_uc;

    logic [7:0] msg_q[$];

    bus_request_parser #(.ACCEPT_LOWERCASE(1'b1)) dut_lc (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .addr_o  (lc_addr),
        .wdata_o (lc_wdata),
        .rdata_o (lc_rdata),
        .rw_o    (lc_rw),
        .valid_o (lc_valid),
        .err_o   (lc_err)
    );

    bus_request_parser #(.ACCEPT_LOWERCASE(1'b0)) dut_uc (
        .clk     (clk),
        .rst_n   (rst_n),
        .data_i  (data_i),
        .valid_i (valid_i),
        .addr_o  (uc_addr),
        .wdata_o (uc_wdata),
        .rdata_o (uc_rdata),
        .rw_o    (uc_rw),
        .valid_o (uc_valid),
        .err_o   (uc_err)
    );

    // 100 MHz clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Single comparison point: counts, and reports any mismatch
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
                     tag, observed, expected, $time);
        end
    endtask

    // Hex value of an ASCII byte, -1 when it is not a digit
    function automatic int hexValue(input logic [7:0] b, input bit lc);
        if (b >= "0" && b <= "9") return int'(b) - int'("0");
        if (b >= "A" && b <= "F") return int'(b) - int'("A") + 10;
        if (lc && b >= "a" && b <= "f") return int'(b) - int'("a") + 10;
        return -1;
    endfunction

    task automatic modelReset(inout model_t m);
        m.in_msg    = 1'b0;
        m.is_wr     = 1'b0;
        m.ndig      = 0;
        m.value     = 0;
        m.exp_valid = 1'b0;
        m.exp_err   = 1'b0;
        m.addr      = '0;
        m.wdata     = '0;
        m.rw        = 1'b0;
    endtask

    task automatic modelStep(inout model_t m, input bit lc, input logic v,
                             input logic [7:0] b);
        int h;
        int need;
        bit term;
        bit start;
        m.exp_valid = 1'b0;
        m.exp_err   = 1'b0;
        if (!v) return;
        h     = hexValue(b, lc);
        term  = (b == 8'h0D) || (b == 8'h0A);
        start = (b == "R") || (b == "W");
        if (!m.in_msg) begin
            if (start) begin
                m.in_msg = 1'b1;
                m.is_wr  = (b == "W");
                m.ndig   = 0;
                m.value  = 0;
            end
            return;
        end
        need = m.is_wr ? 8 : 4;
        if (h >= 0) begin
            if (m.ndig < need) begin
                m.value = m.value * 16 + h;
                m.ndig++;
            end else begin
                m.exp_err = 1'b1;
                m.in_msg  = 1'b0;
            end
        end else if (term) begin
            m.in_msg = 1'b0;
            if (m.ndig == need) begin
                m.exp_valid = 1'b1;
                m.rw        = m.is_wr;
                if (m.is_wr) begin
                    m.addr  = 16'(m.value / 65536);
                    m.wdata = 16'(m.value % 65536);
                end else begin
                    m.addr  = 16'(m.value);
                    m.wdata = 16'h0;
                end
            end else begin
                m.exp_err = 1'b1;
            end
        end else if (start) begin
            m.exp_err = 1'b1;
            m.is_wr   = (b == "W");
            m.ndig    = 0;
            m.value   = 0;
        end else begin
            m.exp_err = 1'b1;
            m.in_msg  = 1'b0;
        end
    endtask

    task automatic checkDuts();
        checkOutput("lc.valid_o", 32'(lc_valid), 32'(m_lc.exp_valid));
        checkOutput("lc.err_o",   32'(lc_err),   32'(m_lc.exp_err));
        checkOutput("lc.addr_o",  32'(lc_addr),  32'(m_lc.addr));
        checkOutput("lc.wdata_o", 32'(lc_wdata), 32'(m_lc.wdata));
        checkOutput("lc.rw_o",    32'(lc_rw),    32'(m_lc.rw));
        checkOutput("lc.rdata_o", 32'(lc_rdata), 32'h0);
        checkOutput("uc.valid_o", 32'(uc_valid), 32'(m_uc.exp_valid));
        checkOutput("uc.err_o",   32'(uc_err),   32'(m_uc.exp_err));
        checkOutput("uc.addr_o",  32'(uc_addr),  32'(m_uc.addr));
        checkOutput("uc.wdata_o", 32'(uc_wdata), 32'(m_uc.wdata));
        checkOutput("uc.rw_o",    32'(uc_rw),    32'(m_uc.rw));
        checkOutput("uc.rdata_o", 32'(uc_rdata), 32'h0);
    endtask

    // One clock: drive on the falling edge, advance models at the rising
    // edge, compare shortly after it
    task automatic applyStimulus(input logic v, input logic [7:0] b);
        @(negedge clk);
        valid_i = v;
        data_i  = b;
        @(posedge clk);
        modelStep(m_lc, 1'b1, v, b);
        modelStep(m_uc, 1'b0, v, b);
        #1;
        checkDuts();
    endtask

    task automatic queueString(input string s);
        for (int i = 0; i < s.len(); i++) msg_q.push_back(s[i]);
    endtask

    // Send the queued bytes, optionally with random idle cycles in between
    task automatic sendQueue(input bit gaps);
        while (msg_q.size() > 0) begin
            if (gaps) begin
                int n = $urandom_range(0, 3);
                for (int g = 0; g < n; g++) applyStimulus(1'b0, 8'($urandom));
            end
            applyStimulus(1'b1, msg_q.pop_front());
        end
        applyStimulus(1'b0, 8'h00);
    endtask

    task automatic sendString(input string s, input bit gaps);
        queueString(s);
        sendQueue(gaps);
    endtask

    function automatic logic [7:0] hexChar(input int h, input bit lower);
        if (h < 10) return 8'(int'("0") + h);
        return lower ? 8'(int'("a") + h - 10) : 8'(int'("A") + h - 10);
    endfunction

    // Mostly well-formed random messages with occasional damage
    task automatic queueRandomMessage();
        bit wr = 1'($urandom);
        int need = wr ? 8 : 4;
        int nd = need;
        int kind = $urandom_range(0, 9);
        if (kind == 0) nd = need - 1;
        if (kind == 1) nd = need + 1;
        msg_q.push_back(wr ? "W" : "R");
        for (int i = 0; i < nd; i++) begin
            msg_q.push_back(hexChar($urandom_range(0, 15), $urandom_range(0, 3) == 0));
            if (kind == 2 && i == 1) msg_q.push_back("G");
            if (kind == 3 && i == 1) msg_q.push_back(($urandom_range(0, 1) == 1) ? "R" : "W");
        end
        msg_q.push_back(($urandom_range(0, 1) == 1) ? 8'h0D : 8'h0A);
        if (kind == 4) msg_q.push_back(8'h0A);
        if (kind == 5) msg_q.push_back(8'($urandom));
    endtask

    // Asynchronous reset with outputs checked while it is held
    task automatic pulseReset();
        @(negedge clk);
        rst_n   = 1'b0;
        valid_i = 1'b0;
        #1;
        modelReset(m_lc);
        modelReset(m_uc);
        checkDuts();
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            checkDuts();
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        check_count = 0;
        pass_count  = 0;
        rst_n   = 1'b0;
        valid_i = 1'b0;
        data_i  = 8'h00;
        modelReset(m_lc);
        modelReset(m_uc);
        #1;
        checkDuts();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] directed messages");
        sendString("R0012\015", 1'b0);
        sendString("W0003BEEF\nR0003\015\n", 1'b0);
        sendString("Wabcd1234\015", 1'b0);
        sendString("R12\015", 1'b0);
        sendString("R12345\015", 1'b0);
        sendString("R00G0\015", 1'b0);
        sendString("W00R0042\015", 1'b0);

        $display("[TB] reset mid-message");
        queueString("W1234AB");
        sendQueue(1'b0);
        pulseReset();
        sendString("R0001\015", 1'b0);
        queueString("W1234AB");
        sendQueue(1'b1);
        pulseReset();
        sendString("R0001\015", 1'b1);

        $display("[TB] random stream");
        for (int k = 0; k < 200; k++) begin
            queueRandomMessage();
            sendQueue(($urandom_range(0, 1) == 1));
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
